// File: rtl/msg_pad_fetch.sv
// msg_pad_fetch: reads a byte-length message from the message SRAM as 32-bit
// words. It appends SHA-256 padding (0x80 byte, zero fill, 64-bit bit length)
// and streams the padded message downstream over valid/ready, 16 words per
// 512-bit block.
// Optional build macro: MSG_PAD_FETCH_LE_SWAP_EN byte-reverses every SRAM word
// so that little-endian message images are hashed in the right byte order.
module msg_pad_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] message_base,
  input  logic [SIZE_WIDTH-1:0] message_size,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_enable,
  output logic                  sram_write,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [31:0]           word_data,
  output logic                  word_block_end,
  output logic                  word_msg_end,
  output logic                  busy,
  output logic                  done
);

  // Word indices need one bit more than the byte size to cover padding.
  localparam int IDX_W = SIZE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef struct packed {
    logic        msg_end;
    logic        block_end;
    logic [31:0] data;
  } entry_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]   base_q;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [IDX_W-1:0]        full_words_q;
  logic [1:0]              rem_q;
  logic [IDX_W-1:0]        total_words_q;
  logic [IDX_W-1:0]        issue_idx;
  logic [IDX_W-1:0]        size_plus_len;
  logic [IDX_W-1:0]        total_words_calc;
  logic [SIZE_WIDTH+2:0]   bit_len_short;
  logic [63:0]             bit_len;

  logic                    issue;
  logic                    issue_read;
  logic                    issue_partial;
  logic [31:0]             issue_gen;
  logic [2:0]              fifo_after;

  logic                    fl_valid;
  logic [IDX_W-1:0]        fl_idx;
  logic                    fl_read;
  logic                    fl_partial;
  logic [31:0]             fl_gen;

  logic [31:0]             sram_word;
  logic [31:0]             land_word;
  logic                    land_block_end;
  logic                    land_msg_end;

  entry_t                  fifo_mem [2];
  logic                    fifo_rd_ptr;
  logic                    fifo_wr_ptr;
  logic [1:0]              fifo_count;
  entry_t                  head;
  logic                    pop;

  // Block count is floor((L+8)/64)+1, so the padded word count is 16 times that.
  assign size_plus_len    = IDX_W'(message_size) + IDX_W'(8);
  assign total_words_calc = ((size_plus_len >> 6) + IDX_W'(1)) << 4;

  // The length field is 8*L formed at SIZE_WIDTH+3 bits, then zero-extended.
  assign bit_len_short = {size_q, 3'b000};
  assign bit_len       = 64'(bit_len_short);

`ifdef MSG_PAD_FETCH_LE_SWAP_EN
  assign sram_word = {sram_read_data[7:0], sram_read_data[15:8],
                      sram_read_data[23:16], sram_read_data[31:24]};
`else
  assign sram_word = sram_read_data[31:0];
`endif

  assign head           = fifo_mem[fifo_rd_ptr];
  assign word_valid     = (fifo_count != 2'd0);
  assign word_data      = word_valid ? head.data : 32'h0;
  assign word_block_end = word_valid & head.block_end;
  assign word_msg_end   = word_valid & head.msg_end;
  assign pop            = word_valid & word_ready;

  assign sram_enable  = issue & issue_read;
  assign sram_address = sram_enable ? base_q + ADDR_WIDTH'(issue_idx) : '0;
  assign sram_write   = 1'b0;

  // State register for the IDLE/STREAM/DONE controller.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; busy spans STREAM and done pulses for the single DONE cycle.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = STREAM;
      STREAM: begin
        busy = 1'b1;
        if (pop && head.msg_end) state_next = DONE;
      end
      DONE:   begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the message geometry on start and step the issue index per launched word.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q        <= '0;
      size_q        <= '0;
      full_words_q  <= '0;
      rem_q         <= '0;
      total_words_q <= '0;
      issue_idx     <= '0;
    end else if (state == IDLE && start) begin
      base_q        <= message_base;
      size_q        <= message_size;
      full_words_q  <= IDX_W'(message_size >> 2);
      rem_q         <= message_size[1:0];
      total_words_q <= total_words_calc;
      issue_idx     <= '0;
    end else if (issue) begin
      issue_idx <= issue_idx + IDX_W'(1);
    end
  end

  // Launch a word only if the FIFO still has room for it when it lands next cycle.
  always_comb begin
    issue_read    = 1'b0;
    issue_partial = 1'b0;
    issue_gen     = 32'h0;
    fifo_after    = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, fl_valid};
    issue         = (state == STREAM) && (issue_idx != total_words_q) &&
                    (fifo_after < 3'd2);
    if (issue_idx < full_words_q) begin
      issue_read = 1'b1;
    end else if (issue_idx == full_words_q) begin
      if (rem_q != 2'd0) begin
        issue_read    = 1'b1;
        issue_partial = 1'b1;
      end else begin
        issue_gen = 32'h8000_0000;
      end
    end else if (issue_idx == total_words_q - IDX_W'(1)) begin
      issue_gen = bit_len[31:0];
    end else if (issue_idx == total_words_q - IDX_W'(2)) begin
      issue_gen = bit_len[63:32];
    end
  end

  // One-slot pipeline holding the word whose SRAM data (if any) arrives next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      fl_valid   <= 1'b0;
      fl_idx     <= '0;
      fl_read    <= 1'b0;
      fl_partial <= 1'b0;
      fl_gen     <= 32'h0;
    end else begin
      fl_valid <= issue;
      if (issue) begin
        fl_idx     <= issue_idx;
        fl_read    <= issue_read;
        fl_partial <= issue_partial;
        fl_gen     <= issue_gen;
      end
    end
  end

  // Build the landing word: full SRAM word, partial word plus 0x80, or a generated word.
  always_comb begin
    land_word = fl_gen;
    if (fl_read) begin
      if (fl_partial) begin
        case (rem_q)
          2'd1:    land_word = {sram_word[31:24], 24'h80_0000};
          2'd2:    land_word = {sram_word[31:16], 16'h8000};
          default: land_word = {sram_word[31:8], 8'h80};
        endcase
      end else begin
        land_word = sram_word;
      end
    end
  end

  assign land_block_end = (fl_idx[3:0] == 4'hF);
  assign land_msg_end   = (fl_idx == total_words_q - IDX_W'(1));

  // Two-entry output FIFO; every landing word is pushed, and the head pops on a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fl_valid) begin
        fifo_mem[fifo_wr_ptr] <= {land_msg_end, land_block_end, land_word};
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, fl_valid} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_msg_pad_fetch.sv
// tb_msg_pad_fetch: randomized bench for msg_pad_fetch. It compares the stream
// with a byte-level SHA-256 padding model and checks the handshake and timing.
module tb_msg_pad_fetch;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int SIZE_WIDTH = 16;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] message_base = '0;
  logic [SIZE_WIDTH-1:0] message_size = '0;
  logic [ADDR_WIDTH-1:0] sram_address;
  logic                  sram_enable;
  logic                  sram_write;
  logic [DATA_WIDTH-1:0] sram_read_data = '0;
  logic                  word_valid;
  logic                  word_ready = 1'b1;
  logic [31:0]           word_data;
  logic                  word_block_end;
  logic                  word_msg_end;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int reads = 0;
  bit write_seen = 1'b0;

  logic [31:0] sram_mem [256];
  logic [31:0] exp_data [$];
  logic [31:0] got_data [$];
  bit          got_be [$];
  bit          got_me [$];
  int          got_edge [$];
  int          first_valid_edge = -1;

  bit          stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic [1:0]  hold_flags = '0;

  always #5 clock = ~clock;

  msg_pad_fetch #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE_WIDTH(SIZE_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .message_base(message_base),
    .message_size(message_size),
    .sram_address(sram_address),
    .sram_enable(sram_enable),
    .sram_write(sram_write),
    .sram_read_data(sram_read_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .word_block_end(word_block_end),
    .word_msg_end(word_msg_end),
    .busy(busy),
    .done(done)
  );

  // Synchronous-read SRAM model and edge counter.
  always @(posedge clock) begin
    cyc_cnt <= cyc_cnt + 1;
    if (sram_enable) begin
      sram_read_data <= sram_mem[sram_address];
      reads <= reads + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Mid-cycle monitor: records transfers and checks stability while stalled.
  always @(negedge clock) begin
    if (sram_write !== 1'b0) write_seen = 1'b1;
    if (stall_prev) begin
      checkOutput("hold_valid", 64'(word_valid), 64'd1);
      checkOutput("hold_data", 64'(word_data), 64'(hold_data));
      checkOutput("hold_flags", 64'({word_block_end, word_msg_end}), 64'(hold_flags));
    end
    if (word_valid && first_valid_edge < 0) first_valid_edge = cyc_cnt;
    if (word_valid && word_ready) begin
      got_data.push_back(word_data);
      got_be.push_back(word_block_end);
      got_me.push_back(word_msg_end);
      got_edge.push_back(cyc_cnt + 1);
    end
    stall_prev = word_valid && !word_ready;
    hold_data  = word_data;
    hold_flags = {word_block_end, word_msg_end};
  end

  // Byte-level SHA-256 padding of the message image held in sram_mem.
  function automatic void buildExpected(input int len, input int base);
    logic [7:0]  bytes_q [$];
    logic [31:0] w;
    logic [63:0] bits;
    exp_data.delete();
    for (int k = 0; k < len; k++) begin
      w = sram_mem[(base + k / 4) % 256];
`ifdef MSG_PAD_FETCH_LE_SWAP_EN
      bytes_q.push_back(w[8 * (k % 4) +: 8]);
`else
      bytes_q.push_back(w[31 - 8 * (k % 4) -: 8]);
`endif
    end
    bytes_q.push_back(8'h80);
    while (bytes_q.size() % 64 != 56) bytes_q.push_back(8'h00);
    bits = 64'(len) * 64'd8;
    for (int j = 7; j >= 0; j--) bytes_q.push_back(bits[8 * j +: 8]);
    for (int i = 0; i < bytes_q.size() / 4; i++)
      exp_data.push_back({bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]});
  endfunction

  function automatic void clearCapture();
    got_data.delete();
    got_be.delete();
    got_me.delete();
    got_edge.delete();
    first_valid_edge = -1;
  endfunction

  // Run one message; rand_ready toggles word_ready, inject_at fires a stray start.
  task automatic applyStimulus(input int len, input int base, input bit rand_ready, input int inject_at);
    int start_edge;
    int done_edge;
    int n;
    int limit;
    buildExpected(len, base);
    n = exp_data.size();
    limit = n * 8 + 40;
    clearCapture();
    @(posedge clock); #1;
    reads = 0;
    start = 1'b1;
    message_base = ADDR_WIDTH'(base);
    message_size = SIZE_WIDTH'(len);
    word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clock); #1;
    start_edge = cyc_cnt;
    start = 1'b0;
    done_edge = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clock);
      if (c == 0) checkOutput("busy_after_start", 64'(busy), 64'd1);
      if (done) begin
        done_edge = cyc_cnt;
        checkOutput("busy_low_at_done", 64'(busy), 64'd0);
        break;
      end
      @(posedge clock); #1;
      word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c == inject_at);
      if (start) begin
        message_base = ADDR_WIDTH'($urandom);
        message_size = SIZE_WIDTH'($urandom_range(1, 500));
      end
    end
    start = 1'b0;
    if (done_edge < 0) checkOutput($sformatf("L%0d_timeout", len), 64'd0, 64'd1);
    checkOutput($sformatf("L%0d_count", len), 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      checkOutput($sformatf("L%0d_w%0d", len, i), 64'(got_data[i]), 64'(exp_data[i]));
      checkOutput($sformatf("L%0d_be%0d", len, i), 64'(got_be[i]), 64'((i % 16) == 15));
      checkOutput($sformatf("L%0d_me%0d", len, i), 64'(got_me[i]), 64'(i == n - 1));
    end
    checkOutput($sformatf("L%0d_reads", len), 64'(reads), 64'((len + 3) / 4));
    if (got_edge.size() > 0)
      checkOutput($sformatf("L%0d_done_edge", len), 64'(done_edge), 64'(got_edge[got_edge.size() - 1]));
    if (!rand_ready && got_edge.size() > 0) begin
      checkOutput($sformatf("L%0d_latency_le3", len), 64'(first_valid_edge - start_edge <= 3), 64'd1);
      checkOutput($sformatf("L%0d_thruput_le_n3", len),
                  64'(got_edge[got_edge.size() - 1] - start_edge <= n + 3), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    bit saw_done;
    for (int i = 0; i < 256; i++) sram_mem[i] = $urandom;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_sram", 64'({sram_address, sram_enable, sram_write}), 64'd0);
    checkOutput("rst_word", 64'({word_valid, word_data, word_block_end, word_msg_end}), 64'd0);
    checkOutput("rst_busy_done", 64'({busy, done}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    applyStimulus(0, $urandom_range(0, 255), 1'b0, -1);
    checkOutput("L0_first", 64'(got_data.size() > 0 ? got_data[0] : 32'h0), 64'h8000_0000);

    b = $urandom_range(0, 255);
    sram_mem[b] = 32'h6162_6364;
    applyStimulus(3, b, 1'b0, -1);
`ifndef MSG_PAD_FETCH_LE_SWAP_EN
    checkOutput("L3_word0", 64'(got_data.size() > 0 ? got_data[0] : 32'h0), 64'h6162_6380);
`endif
    checkOutput("L3_word15", 64'(got_data.size() > 15 ? got_data[15] : 32'h0), 64'h18);

    applyStimulus(55, $urandom_range(0, 255), 1'b0, -1);
    checkOutput("L55_word15", 64'(got_data.size() > 15 ? got_data[15] : 32'h0), 64'h1B8);

    applyStimulus(56, $urandom_range(0, 255), 1'b0, -1);
    checkOutput("L56_word14", 64'(got_data.size() > 14 ? got_data[14] : 32'h0), 64'h8000_0000);
    checkOutput("L56_word31", 64'(got_data.size() > 31 ? got_data[31] : 32'h0), 64'h1C0);

    b = $urandom_range(0, 255);
    applyStimulus(64, b, 1'b0, -1);
    applyStimulus(64, b, 1'b1, 10);

    applyStimulus(40, 250, 1'b1, -1);

    for (int t = 0; t < 5; t++)
      applyStimulus($urandom_range(0, 200), $urandom_range(0, 255), 1'b1, -1);

    b = $urandom_range(0, 255);
    clearCapture();
    @(posedge clock); #1;
    word_ready = 1'b1;
    start = 1'b1;
    message_base = ADDR_WIDTH'(b);
    message_size = SIZE_WIDTH'(100);
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && got_data.size() < 5; c++) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_sram", 64'({sram_address, sram_enable, sram_write}), 64'd0);
    checkOutput("abort_word", 64'({word_valid, word_data, word_block_end, word_msg_end}), 64'd0);
    checkOutput("abort_busy_done", 64'({busy, done}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done || busy || word_valid) saw_done = 1'b1;
    end
    checkOutput("abort_quiet", 64'(saw_done), 64'd0);
    applyStimulus(100, b, 1'b0, -1);

    checkOutput("sram_write_low", 64'(write_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
